// File: rtl/match_network_pkg.sv
// Shared widths, header constants and bundle types for the packet
// classification cluster.
package match_network_pkg;

  localparam int DATA_W = 128;
  localparam int CH_W   = 8;
  localparam int TAG_W  = 10;
  localparam int BEAT_W = 138;

  localparam logic [15:0] ETH_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_ICMP  = 8'h01;

  typedef struct packed {
    logic [CH_W-1:0]   channel;
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef struct packed {
    logic            ipv4;
    logic            icmp;
    logic [CH_W-1:0] channel;
  } tag_t;

endpackage

// File: rtl/match_network_node.sv
// One match node: beat FIFO, Ethernet/IPv4 header parser and tag FIFO.
// Parsed tags pass through one pending register before the tag FIFO.
module match_node
  import match_network_pkg::*;
#(
  parameter int IN_DEPTH  = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic  clock,
  input  logic  sclr,
  input  logic  push,
  input  beat_t push_beat,
  input  logic  freeze,
  input  logic  tag_pop,
  output logic  in_full,
  output logic  tag_valid,
  output tag_t  tag_head
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int ICW = IAW + 1;
  localparam int TAW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int TCW = $clog2(TAG_DEPTH + 1);
  localparam logic [ICW-1:0] IN_FULL  = ICW'(IN_DEPTH);
  localparam logic [TCW-1:0] TAG_FULL = TCW'(TAG_DEPTH);
  localparam logic [TAW-1:0] TAG_LAST = TAW'(TAG_DEPTH - 1);

  beat_t          in_mem_q [IN_DEPTH];
  logic [IAW-1:0] in_rd_q, in_rd_d, in_wr_q, in_wr_d;
  logic [ICW-1:0] in_cnt_q, in_cnt_d;
  tag_t           tg_mem_q [TAG_DEPTH];
  logic [TAW-1:0] tg_rd_q, tg_rd_d, tg_wr_q, tg_wr_d;
  logic [TCW-1:0] tg_cnt_q, tg_cnt_d;
  logic [1:0]     idx_q, idx_d;
  logic           ipv4_q, ipv4_d, icmp_q, icmp_d;
  logic           pend_q, pend_d;
  tag_t           pend_tag_q, pend_tag_d;

  beat_t      head;
  logic [1:0] idx;
  logic       push_ok, pop, room, tag_wr, tg_pop;

  always_comb begin
    head      = in_mem_q[in_rd_q];
    in_full   = (in_cnt_q == IN_FULL);
    tag_valid = (tg_cnt_q != '0);
    tag_head  = tg_mem_q[tg_rd_q];
    push_ok   = push & ~in_full;
    // the pending tag already owns a slot
    room      = (tg_cnt_q + TCW'(pend_q)) < TAG_FULL;
    pop       = (in_cnt_q != '0) & ~freeze & room;
    tag_wr    = pend_q & ~freeze;
    tg_pop    = tag_pop & tag_valid;
    idx       = head.sop ? 2'd0 : idx_q;

    idx_d      = idx_q;
    ipv4_d     = ipv4_q;
    icmp_d     = icmp_q;
    pend_d     = pend_q & ~tag_wr;
    pend_tag_d = pend_tag_q;
    if (pop) begin
      unique case (idx)
        2'd0: begin
          ipv4_d = (head.data[31:16] == ETH_IPV4);
          icmp_d = 1'b0;
        end
        2'd1: icmp_d = ipv4_q & (head.data[71:64] == IP_ICMP);
        default: icmp_d = icmp_q;
      endcase
      idx_d = (idx == 2'd2) ? idx : idx + 2'd1;
      if (head.eop) begin
        pend_d             = 1'b1;
        pend_tag_d.ipv4    = ipv4_d;
        pend_tag_d.icmp    = icmp_d;
        pend_tag_d.channel = head.channel;
      end
    end

    in_wr_d  = push_ok ? in_wr_q + IAW'(1) : in_wr_q;
    in_rd_d  = pop ? in_rd_q + IAW'(1) : in_rd_q;
    in_cnt_d = in_cnt_q + ICW'(push_ok) - ICW'(pop);
    tg_wr_d  = tg_wr_q;
    if (tag_wr) tg_wr_d = (tg_wr_q == TAG_LAST) ? '0 : tg_wr_q + TAW'(1);
    tg_rd_d  = tg_rd_q;
    if (tg_pop) tg_rd_d = (tg_rd_q == TAG_LAST) ? '0 : tg_rd_q + TAW'(1);
    tg_cnt_d = tg_cnt_q + TCW'(tag_wr) - TCW'(tg_pop);
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      in_rd_q    <= '0;
      in_wr_q    <= '0;
      in_cnt_q   <= '0;
      tg_rd_q    <= '0;
      tg_wr_q    <= '0;
      tg_cnt_q   <= '0;
      idx_q      <= '0;
      ipv4_q     <= 1'b0;
      icmp_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_tag_q <= '0;
    end else begin
      in_rd_q    <= in_rd_d;
      in_wr_q    <= in_wr_d;
      in_cnt_q   <= in_cnt_d;
      tg_rd_q    <= tg_rd_d;
      tg_wr_q    <= tg_wr_d;
      tg_cnt_q   <= tg_cnt_d;
      idx_q      <= idx_d;
      ipv4_q     <= ipv4_d;
      icmp_q     <= icmp_d;
      pend_q     <= pend_d;
      pend_tag_q <= pend_tag_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) in_mem_q[in_wr_q] <= push_beat;
    if (tag_wr)  tg_mem_q[tg_wr_q] <= pend_tag_q;
  end

endmodule

// File: rtl/match_network.sv
// Packet classification cluster: round-robin packet dispatch to match
// nodes and in-order tag collection through a dispatch-order FIFO.
module match_network
  import match_network_pkg::*;
#(
  parameter int ncount    = 8,
  parameter int IN_DEPTH  = 16,
  parameter int TAG_DEPTH = 4,
  parameter int ORD_DEPTH = 32
) (
  input  logic              clock,
  input  logic              sclr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_valid,
  input  logic              st_sop,
  input  logic              st_eop,
  input  logic [CH_W-1:0]   st_channel,
  output logic              st_ready,
  output logic [TAG_W-1:0]  tag_data,
  output logic              tag_valid,
  input  logic              tag_ready,
  input  logic [ncount-1:0] node_enable,
  input  logic [ncount-1:0] node_freeze,
  input  logic              global_freeze
);

  localparam int IW  = (ncount > 1) ? $clog2(ncount) : 1;
  localparam int OAW = $clog2(ORD_DEPTH);
  localparam int OCW = OAW + 1;
  localparam logic [IW-1:0] LAST = IW'(ncount - 1);

  logic            in_pkt_q, in_pkt_d;
  logic [IW-1:0]   ptr_q, ptr_d, cur_q, cur_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [IW-1:0]   ord_mem_q [ORD_DEPTH];
  logic [OAW-1:0]  ord_rd_q, ord_rd_d, ord_wr_q, ord_wr_d;
  logic [OCW-1:0]  ord_cnt_q, ord_cnt_d;

  logic [IW-1:0]     tgt, scan, dest, ord_head;
  logic              any_en, acc, take, ord_full, ord_push, ord_pop;
  beat_t             beat_in;
  logic [ncount-1:0] push_v, in_full_v, tg_valid_v, tg_pop_v;
  tag_t              tg_head_v [ncount];

  // first enabled node at or after the pointer, wrapping
  always_comb begin
    tgt    = '0;
    any_en = 1'b0;
    scan   = ptr_q;
    for (int k = 0; k < ncount; k++) begin
      if (!any_en && node_enable[scan]) begin
        any_en = 1'b1;
        tgt    = scan;
      end
      scan = (scan == LAST) ? '0 : scan + IW'(1);
    end
  end

  always_comb begin
    ord_full = (ord_cnt_q == OCW'(ORD_DEPTH));
    ord_head = ord_mem_q[ord_rd_q];
    dest     = in_pkt_q ? cur_q : tgt;

    if (sclr)          st_ready = 1'b0;
    else if (in_pkt_q) st_ready = ~in_full_v[cur_q];
    else if (!any_en)  st_ready = 1'b0;
    else if (!st_sop)  st_ready = 1'b1;
    else               st_ready = ~in_full_v[tgt] & ~ord_full;

    acc  = st_valid & st_ready;
    // idle beats without sop are accepted and dropped
    take = acc & (in_pkt_q | st_sop);

    beat_in.channel = in_pkt_q ? ch_q : st_channel;
    beat_in.sop     = ~in_pkt_q;
    beat_in.eop     = st_eop;
    beat_in.data    = st_data;

    in_pkt_d = in_pkt_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    ch_d     = ch_q;
    ord_push = take & ~in_pkt_q;
    if (take) begin
      if (!in_pkt_q) begin
        cur_d = tgt;
        ch_d  = st_channel;
      end
      if (st_eop) begin
        in_pkt_d = 1'b0;
        ptr_d    = (dest == LAST) ? '0 : dest + IW'(1);
      end else begin
        in_pkt_d = 1'b1;
      end
    end

    tag_valid = ~sclr & (ord_cnt_q != '0) & tg_valid_v[ord_head];
    tag_data  = tag_valid ? tg_head_v[ord_head] : '0;
    ord_pop   = tag_valid & tag_ready;

    ord_wr_d  = ord_push ? ord_wr_q + OAW'(1) : ord_wr_q;
    ord_rd_d  = ord_pop ? ord_rd_q + OAW'(1) : ord_rd_q;
    ord_cnt_d = ord_cnt_q + OCW'(ord_push) - OCW'(ord_pop);
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      in_pkt_q  <= 1'b0;
      ptr_q     <= '0;
      cur_q     <= '0;
      ch_q      <= '0;
      ord_rd_q  <= '0;
      ord_wr_q  <= '0;
      ord_cnt_q <= '0;
    end else begin
      in_pkt_q  <= in_pkt_d;
      ptr_q     <= ptr_d;
      cur_q     <= cur_d;
      ch_q      <= ch_d;
      ord_rd_q  <= ord_rd_d;
      ord_wr_q  <= ord_wr_d;
      ord_cnt_q <= ord_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (ord_push) ord_mem_q[ord_wr_q] <= tgt;
  end

  for (genvar i = 0; i < ncount; i++) begin : g_node
    assign push_v[i]   = take & (dest == IW'(i));
    assign tg_pop_v[i] = ord_pop & (ord_head == IW'(i));

    match_node #(
      .IN_DEPTH  (IN_DEPTH),
      .TAG_DEPTH (TAG_DEPTH)
    ) u_node (
      .clock     (clock),
      .sclr      (sclr),
      .push      (push_v[i]),
      .push_beat (beat_in),
      .freeze    (node_freeze[i] | global_freeze),
      .tag_pop   (tg_pop_v[i]),
      .in_full   (in_full_v[i]),
      .tag_valid (tg_valid_v[i]),
      .tag_head  (tg_head_v[i])
    );
  end

endmodule

// File: tb/tb_match_network.sv
// Directed bench for match_network: dispatch order, parsing, latency,
// freeze, backpressure, enable gating and mid-packet reset.
module tb_match_network;

  logic         clock = 1'b0;
  logic         sclr;
  logic [127:0] st_data;
  logic         st_valid, st_sop, st_eop;
  logic [7:0]   st_channel;
  logic         st_ready;
  logic [9:0]   tag_data;
  logic         tag_valid, tag_ready;
  logic [7:0]   node_enable, node_freeze;
  logic         global_freeze;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] got_q[$];

  localparam logic [127:0] B0 = 128'h004e46324302004e4632430208004500;
  localparam logic [127:0] B1 = 128'h005C0000400040011F9B0A0203020A01;
  localparam logic [127:0] B6 = 128'h004e46324302004e4632430286DD4500;

  match_network u_dut (
    .clock         (clock),
    .sclr          (sclr),
    .st_data       (st_data),
    .st_valid      (st_valid),
    .st_sop        (st_sop),
    .st_eop        (st_eop),
    .st_channel    (st_channel),
    .st_ready      (st_ready),
    .tag_data      (tag_data),
    .tag_valid     (tag_valid),
    .tag_ready     (tag_ready),
    .node_enable   (node_enable),
    .node_freeze   (node_freeze),
    .global_freeze (global_freeze)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (tag_valid && tag_ready) got_q.push_back(tag_data);
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] pdat(input int i, input logic [127:0] b0,
                                        input logic [127:0] b1);
    if (i == 0) return b0;
    if (i == 1) return b1;
    return {32'(i), 96'h0};
  endfunction

  function automatic logic [9:0] pop_tag();
    if (got_q.size() == 0) return 10'h3ff;
    return got_q.pop_front();
  endfunction

  task automatic send_beat(input logic [127:0] d, input logic sop,
                           input logic eop, input logic [7:0] ch,
                           input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    st_data = d; st_sop = sop; st_eop = eop; st_channel = ch;
    st_valid = 1'b1;
    while (!ok && n < budget) begin
      #1;
      ok = st_ready;
      @(posedge clock);
      #1;
      n++;
    end
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] ch, input int nb,
                          input logic [127:0] b0, input logic [127:0] b1,
                          input bit gap, input int budget, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < nb && ok; i++) begin
      if (gap && (i % 2 == 1)) step();
      send_beat(pdat(i, b0, b1), i == 0, i == nb - 1, ch, budget, ok);
    end
  endtask

  task automatic wait_tags(input string tag, input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      step();
      c++;
    end
    check(tag, got_q.size(), n);
  endtask

  task automatic do_reset();
    sclr = 1'b1;
    step();
    sclr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc_pkts;
    sclr = 1'b1; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    st_data = '0; st_channel = '0; tag_ready = 1'b0;
    node_enable = 8'h00; node_freeze = 8'h00; global_freeze = 1'b0;
    step();
    step();
    check("rst_rdy", st_ready, 1'b0);
    check("rst_tv", tag_valid, 1'b0);
    check("rst_td", tag_data, 10'h000);
    sclr = 1'b0;
    #1;
    check("noen_rdy", st_ready, 1'b0);
    node_enable = 8'h01;
    #1;
    check("idle_rdy", st_ready, 1'b1);
    step();

    // single 7-beat IPv4/ICMP packet, gapped valid
    send_pkt(8'd5, 7, B0, B1, 1'b1, 20, ok);
    check("t1_acc", ok, 1'b1);
    check("t1_lat0", tag_valid, 1'b0);
    step();
    check("t1_lat1", tag_valid, 1'b0);
    step();
    check("t1_lat2", tag_valid, 1'b1);
    check("t1_tag", tag_data, 10'h305);
    tag_ready = 1'b1;
    step();
    check("t1_pop", tag_valid, 1'b0);
    got_q.delete();

    // non-IPv4 frame
    send_pkt(8'd3, 2, B6, B1, 1'b1, 20, ok);
    check("t2_acc", ok, 1'b1);
    wait_tags("t2_cnt", 1, 50);
    check("t2_tag", pop_tag(), 10'h003);

    // nodes 0 and 2, node 2 frozen
    do_reset();
    node_enable = 8'h05;
    node_freeze = 8'h04;
    got_q.delete();
    for (int p = 1; p <= 4; p++) begin
      send_pkt(8'(p), 2, B0, B1, 1'b1, 20, ok);
      check("t3_acc", ok, 1'b1);
    end
    repeat (10) step();
    check("t3_frz_cnt", got_q.size(), 1);
    check("t3_first", pop_tag(), 10'h301);
    node_freeze = 8'h00;
    wait_tags("t3_cnt", 3, 50);
    check("t3_tag2", pop_tag(), 10'h302);
    check("t3_tag3", pop_tag(), 10'h303);
    check("t3_tag4", pop_tag(), 10'h304);

    // backpressure: 4 tags + 16 beats fill node 0
    node_enable = 8'h01;
    tag_ready = 1'b0;
    acc_pkts = 0;
    for (int p = 0; p < 16; p++) begin
      send_pkt(8'(16 + p), 2, B0, B1, 1'b0, 8, ok);
      if (!ok) break;
      acc_pkts++;
    end
    check("bp_pkts", acc_pkts, 12);
    st_valid = 1'b1; st_sop = 1'b1;
    #1;
    check("bp_rdy", st_ready, 1'b0);
    st_valid = 1'b0; st_sop = 1'b0;
    tag_ready = 1'b1;
    wait_tags("bp_cnt", 12, 200);
    for (int p = 0; p < 12; p++)
      check("bp_tag", pop_tag(), 10'h300 | 10'(16 + p));
    repeat (5) step();
    check("bp_extra", got_q.size(), 0);

    // enable gating and pre-sop discard
    node_enable = 8'h00;
    st_valid = 1'b1; st_sop = 1'b1;
    #1;
    check("noen_sop", st_ready, 1'b0);
    st_valid = 1'b0; st_sop = 1'b0;
    step();
    node_enable = 8'h01;
    for (int i = 0; i < 3; i++) begin
      send_beat(B0, 1'b0, i == 2, 8'd9, 4, ok);
      check("pre_acc", ok, 1'b1);
    end
    repeat (10) step();
    check("pre_none", got_q.size(), 0);
    check("pre_tv", tag_valid, 1'b0);

    // reset in the middle of a packet with a tag pending
    node_enable = 8'hFF;
    tag_ready = 1'b0;
    send_pkt(8'd7, 2, B0, B1, 1'b0, 20, ok);
    check("rs_acc", ok, 1'b1);
    send_beat(B0, 1'b1, 1'b0, 8'd8, 20, ok);
    send_beat(B1, 1'b0, 1'b0, 8'd8, 20, ok);
    repeat (3) step();
    sclr = 1'b1;
    #1;
    check("rs_rdy", st_ready, 1'b0);
    check("rs_tv", tag_valid, 1'b0);
    step();
    sclr = 1'b0;
    #1;
    check("rs_tv_after", tag_valid, 1'b0);
    check("rs_td_after", tag_data, 10'h000);
    node_freeze = 8'hFE;
    tag_ready = 1'b1;
    got_q.delete();
    send_pkt(8'd9, 2, B0, B1, 1'b0, 20, ok);
    check("rs_acc2", ok, 1'b1);
    wait_tags("rs_cnt", 1, 50);
    check("rs_tag", pop_tag(), 10'h309);
    repeat (10) step();
    check("rs_once", got_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/match_network.md
Name: match_network

Overview:
- Packet classification cluster: an input distribution network, `ncount` match nodes, and an in-order tag collection network.
- Accepts an Avalon-ST style 128-bit packet stream. Dispatches whole packets round-robin to enabled match nodes.
- Each node parses Ethernet/IPv4 headers and emits one 10-bit tag per packet.
- Tags leave on a single ready/valid port in packet-arrival order.

Parameters:
- ncount, 8, number of match nodes (1..16).
- IN_DEPTH, 16, beats per node input FIFO (power of 2).
- TAG_DEPTH, 4, tags per node tag FIFO.
- ORD_DEPTH, 32, entries in the dispatch-order FIFO (power of 2).

Ports:
- clock  in  1  sole clock, rising edge.
- sclr  in  1  reset, synchronous, active-high.
- st_data  in  128  packet beat; byte 0 of the beat is st_data[127:120].
- st_valid  in  1  beat valid.
- st_sop  in  1  first beat of packet.
- st_eop  in  1  last beat of packet.
- st_channel  in  8  packet channel, sampled on sop beat.
- st_ready  out  1  beat accepted when st_valid & st_ready.
- tag_data  out  10  classification tag.
- tag_valid  out  1  tag available.
- tag_ready  in  1  tag consumed when tag_valid & tag_ready.
- node_enable  in  ncount  per-node enable; disabled nodes receive no new packets.
- node_freeze  in  ncount  per-node freeze.
- global_freeze  in  1  freezes all nodes.

Behaviour:
- Reset (sclr=1 at an edge), regardless of packet state:
  - all FIFOs emptied; dispatcher returns to idle and node pointer to 0;
  - st_ready=0 and tag_valid=0 during the reset cycle;
  - tag_data=0 whenever tag_valid=0.
- Dispatcher, idle (outside a packet):
  - Target node is the next enabled node at or after the pointer, wrapping.
  - If no node is enabled, st_ready=0.
  - Beats with st_valid & !st_sop are accepted (st_ready=1) and discarded.
- Dispatcher, sop beat:
  - Accepted only if the target input FIFO is not full and the order FIFO is not full.
  - On acceptance: push the target index into the order FIFO, latch st_channel, enter in-packet state.
- Dispatcher, in-packet:
  - All beats go to the latched node.
  - st_ready = that node's input FIFO not full.
  - st_sop inside a packet is ignored.
  - The eop beat returns the dispatcher to idle; pointer = latched node + 1 (mod ncount).
  - node_enable changes take effect only at the next sop.
- FIFO entry format: 138-bit entry = {channel[7:0], sop, eop, data[127:0]}, written on the accepting edge.
- Match node:
  - Pops one beat per cycle when its input FIFO is non-empty, it is not frozen (node_freeze[i] | global_freeze), and its tag FIFO is not full.
  - Beat index counter resets at sop.
  - Beat 0: ipv4 = (data[31:16] == 16'h0800).
  - Beat 1: icmp = ipv4 & (data[71:64] == 8'h01).
  - Packets shorter than 2 beats give icmp=0.
  - On popping the eop beat, write tag {ipv4, icmp, channel} into the tag FIFO on the next edge.
- Latency: with empty pipeline, tag_valid rises after the 2nd rising edge following eop acceptance.
- Collector:
  - tag_valid = order FIFO non-empty and the head node's tag FIFO non-empty.
  - tag_data = that tag FIFO's head.
  - On handshake, pop both.
  - Tags are never reordered; a slow node blocks later tags.
- Backpressure: tag_ready=0 fills tag FIFOs, then input FIFOs, then deasserts st_ready. No beat or tag is ever dropped except pre-sop beats.
- Freeze: stops pops and tag writes only; dispatch into the node's FIFO continues until full.
- Simultaneous push/pop on a full FIFO: pop takes effect, push is blocked by the not-full check evaluated before the edge.

Decomposition:
- Package match_network_pkg:
  - DATA_W=128, CH_W=8, TAG_W=10, BEAT_W=138;
  - packed struct for the beat {channel, sop, eop, data};
  - packed struct for the tag {ipv4, icmp, channel};
  - ETH_IPV4=16'h0800, IP_ICMP=8'h01.
- Sub-module match_node: input FIFO, parser, tag FIFO. Instantiated ncount times in a generate loop.
- Dispatcher, order FIFO and collector stay in the top.

Test Plan:
- Single packet, node_enable=8'h01, channel 5:
  - Beat 0 is 128'h004e46324302004e4632430208004500 with sop. Then 128'h005C0000400040011F9B0A0203020A01. Then five more beats, last with eop. Valid has gaps.
  - Required: one tag 10'h305, tag_valid 2 edges after eop acceptance.
- Non-IPv4 frame, channel 3 (beat 0 data[31:16]=16'h86DD) -> tag 10'h003.
- Four 2-beat ICMP packets, node_enable=8'h05, channels 1..4:
  - Dispatched to nodes 0,2,0,2.
  - Required tags 10'h301, 10'h302, 10'h303, 10'h304 in order; node 2 frozen during the run still yields the same order.
- tag_ready=0 with continuous input -> st_ready falls once FIFOs fill; no loss after release, tag count equals packet count.
- node_enable=0 -> st_ready=0 on sop beats; pre-sop beats with enable=1 are discarded, no tag.
- sclr asserted mid-packet -> next cycle tag_valid=0; subsequent fresh packet yields exactly one correct tag, dispatched to node 0.
